// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide share one 64-bit accumulator, one bit per cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;
  logic        zero_q, zero_d;
  logic        is_div_q, is_div_d;
  logic        neg_p_q, neg_p_d;
  logic        neg_r_q, neg_r_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        op_signed, a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    op_signed = ~op_code[0];
    a_neg     = op_signed & rs_val[31];
    b_neg     = op_signed & rt_val[31];
    mag_a     = a_neg ? (32'd0 - rs_val) : rs_val;
    mag_b     = b_neg ? (32'd0 - rt_val) : rt_val;

    // Multiply: acc = {partial product, remaining multiplier bits}
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    // Divide: acc = {partial remainder, remaining dividend / growing quotient}
    rem_sh    = {acc_q[63:32], acc_q[31]};
    rem_diff  = rem_sh - {1'b0, opb_q};

    prod_fix  = neg_p_q ? (64'd0 - acc_q) : acc_q;
    quo_fix   = neg_p_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_fix   = neg_r_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    zero_d   = zero_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (op_valid && !cancel) begin
          unique case (op_code)
            OP_MULT, OP_MULTU: begin
              neg_p_d  = a_neg ^ b_neg;
              neg_r_d  = a_neg;
              is_div_d = 1'b0;
              zero_d   = 1'b0;
              cnt_d    = 5'd0;
              acc_d    = {32'd0, mag_b};
              opb_d    = mag_a;
              state_d  = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              neg_p_d  = a_neg ^ b_neg;
              neg_r_d  = a_neg;
              is_div_d = 1'b1;
              cnt_d    = 5'd0;
              acc_d    = {32'd0, mag_a};
              opb_d    = mag_b;
              zero_d   = (rt_val == 32'd0);
              state_d  = (rt_val == 32'd0) ? S_FIX : S_DIV;
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_DIV: begin
        if (!rem_diff[32]) acc_d = {rem_diff[31:0], acc_q[30:0], 1'b1};
        else               acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (zero_q) begin
          dbz_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flush abandons whatever is in flight, including a FIX write-back.
    if (cancel) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      zero_q   <= 1'b0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opb_q    <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      zero_q   <= zero_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: driver pushes expected {div_by_zero, hi, lo}
// into a queue, a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int ACT_NONE   = 0;
  localparam int ACT_INJECT = 1;
  localparam int ACT_CANCEL = 2;
  localparam int ACT_RESET  = 3;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        cancel;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [64:0] exp_q[$];
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;
  int          n_checks;
  int          n_pass;
  int          n_fail;

  muldiv_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .cancel      (cancel),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // driver tasks: all are entered and left on a falling edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op_code  = op;
    rs_val   = a;
    rt_val   = b;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_idle(input int act, input int act_at, output int n);
    bit hold_ok;
    hold_ok = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (hi !== cur_hi || lo !== cur_lo) hold_ok = 1'b0;
      if (n == act_at) begin
        if (act == ACT_INJECT) begin
          op_valid = 1'b1;
          op_code  = OP_MULTU;
          rs_val   = 32'd2;
          rt_val   = 32'd3;
        end else if (act == ACT_CANCEL) begin
          cancel = 1'b1;
        end else if (act == ACT_RESET) begin
          rst_n = 1'b0;
        end
      end
      @(negedge clk);
      op_valid = 1'b0;
      cancel   = 1'b0;
      rst_n    = 1'b1;
    end
    check("hold_during_busy", 64'(hold_ok), 64'd1);
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int exp_n, input int act, input int act_at,
                     input bit expect_done, input logic dbz,
                     input logic [31:0] nhi, input logic [31:0] nlo);
    int n;
    if (expect_done) exp_q.push_back({dbz, nhi, nlo});
    issue(op, a, b);
    wait_idle(act, act_at, n);
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_n));
    if (expect_done) begin
      cur_hi = nhi;
      cur_lo = nlo;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [64:0] e;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_hi", 64'(hi), 64'(e[63:32]));
        check("done_lo", 64'(lo), 64'(e[31:0]));
        check("done_dbz", 64'(div_by_zero), 64'(e[64]));
      end
    end else if (div_by_zero) begin
      check("dbz_without_done", 64'(div_by_zero), 64'd0);
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    cur_hi   = 32'd0;
    cur_lo   = 32'd0;
    rst_n    = 1'b0;
    op_valid = 1'b0;
    op_code  = 3'd0;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    cancel   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);

    // first edge out of reset accepts MTHI
    rst_n = 1'b1;
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    cur_hi = 32'h1234_5678;
    check("mthi_hi", 64'(hi), 64'(cur_hi));
    issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
    cur_lo = 32'h9ABC_DEF0;
    check("mtlo_lo", 64'(lo), 64'(cur_lo));
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_done", 64'(done), 64'd0);

    cancel = 1'b1;
    issue(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
    cancel = 1'b0;
    check("cancel_mtlo_lo", 64'(lo), 64'(cur_lo));

    issue(3'b110, 32'h1111_1111, 32'h2222_2222);
    check("ignored_op_busy", 64'(busy), 64'd0);
    check("ignored_op_hi", 64'(hi), 64'(cur_hi));
    check("ignored_op_lo", 64'(lo), 64'(cur_lo));

    run("div_zero", OP_DIV, 32'd5, 32'd0, 1, ACT_NONE, 0, 1'b1, 1'b1,
        32'h1234_5678, 32'h9ABC_DEF0);
    run("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 33, ACT_NONE, 0, 1'b1, 1'b0,
        32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, ACT_INJECT, 5, 1'b1, 1'b0,
        32'hFFFF_FFFE, 32'h0000_0001);
    run("multu_pow", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 33, ACT_NONE, 0, 1'b1, 1'b0,
        32'h0000_0001, 32'h0000_0000);
    run("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 33, ACT_NONE, 0, 1'b1, 1'b0,
        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_7_neg2", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 33, ACT_NONE, 0, 1'b1, 1'b0,
        32'h0000_0001, 32'hFFFF_FFFD);
    run("div_minint", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, ACT_NONE, 0, 1'b1, 1'b0,
        32'h0000_0000, 32'h8000_0000);

    run("divu_cancel", OP_DIVU, 32'd100, 32'd7, 10, ACT_CANCEL, 10, 1'b0, 1'b0, 32'd0, 32'd0);
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_done", 64'(done), 64'd0);
    check("cancel_hi", 64'(hi), 64'(cur_hi));
    check("cancel_lo", 64'(lo), 64'(cur_lo));
    repeat (3) @(negedge clk);

    run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33, ACT_NONE, 0, 1'b1, 1'b0, 32'd2, 32'd14);
    @(negedge clk);

    run("mult_reset", OP_MULT, 32'd3, 32'd5, 20, ACT_RESET, 20, 1'b0, 1'b0, 32'd0, 32'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    check("reset_mid_hi", 64'(hi), 64'd0);
    check("reset_mid_lo", 64'(lo), 64'd0);
    check("reset_mid_busy", 64'(busy), 64'd0);
    check("reset_mid_done", 64'(done), 64'd0);
    repeat (40) @(negedge clk);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
